wave_voice_sched: RTL and testbench
===================================

// Module: wave_voice_sched
// PURPOSE
//  Time-multiplexes one shared 64-entry wave lookup table (6-bit ramp in, 16-bit sample out) across
//  NUM_VOICES tone voices. Holds per-voice phase accumulators and CPU-written pitch/control registers.
//  On each sample strobe, walks voices one per clock, sums their LUT samples and emits one mixed sample.
//  Sits between the CPU audio register bus and the audio DAC/PWM path.
// PARAMETERS
//  NUM_VOICES  4   voice count; power of 2, 2..8
//  PHASE_W     16  phase accumulator width; ramp = phase[PHASE_W-1 -: 6]
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  sample_stb   in   1   1-cycle pulse: start a new mixed sample
//  wr_en        in   1   register write strobe
//  wr_addr      in   AW  AW=$clog2(NUM_VOICES)+1; {voice, sel}; sel 0=INC, 1=CTRL
//  wr_data      in   16  INC: phase increment; CTRL: [0]=enable, [2:1]=atten (VOICE_ATTEN_EN only)
//  ramp_o       out  6   address to shared LUT (combinational from current voice phase)
//  lut_i        in   16  LUT sample for ramp_o, same cycle (combinational LUT)
//  mix_o        out  16  mixed sample, held between updates
//  mix_valid_o  out  1   1-cycle pulse when mix_o updates
//  busy_o       out  1   high while state != IDLE
//  overrun_o    out  1   1-cycle pulse: sample_stb arrived while busy
// BEHAVIOUR
//  Reset: all phase/INC/CTRL regs 0, state IDLE, idx 0, acc 0; mix_o=0, mix_valid_o=0, busy_o=0,
//   overrun_o=0, ramp_o=0. Reset is honoured mid-walk: partial mix discarded, no valid pulse.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: sample_stb=1 at edge E0 -> RUN, idx=0, acc=0. ramp_o=0.
//   RUN: ramp_o=phase[idx] top 6 bits. At each edge: acc += contrib(idx); if enable[idx]
//    phase[idx] += INC[idx] (mod 2^PHASE_W, wraps silently) else phase[idx]=0; idx++.
//    After edge E_NUM_VOICES -> DONE.
//   DONE: at edge, mix_o = acc >> $clog2(NUM_VOICES) (acc width 16+$clog2(NUM_VOICES), no overflow);
//    mix_valid_o high the following cycle; -> IDLE. Latency: strobe edge to valid = NUM_VOICES+2 edges.
//  contrib = enable ? lut_i : 0 (disabled voice is silent, not LUT[0]).
//  sample_stb while busy_o: ignored, overrun_o pulses next cycle; walk unaffected.
//  sample_stb in the DONE->IDLE edge counts as busy (ignored). Next accepted strobe only in IDLE.
//  Register writes apply at the edge; the voice being walked in that cycle uses pre-write values.
//  Writing enable=0 zeroes that voice's phase on its next walk slot; re-enable restarts from phase 0.
// CONFIGURATION
//  VOICE_ATTEN_EN defined: contrib = (enable ? lut_i : 0) >> atten (0..3); CTRL[2:1] stored.
//  VOICE_ATTEN_EN undefined: CTRL[2:1] ignored and not stored; contrib full scale.
// STRUCTURE
//  Package wave_voice_pkg: state enum {IDLE,RUN,DONE}, REG_INC=0/REG_CTRL=1 selectors,
//   RAMP_W=6, SAMPLE_W=16, CTRL bit positions.
//  Sub-module wave_voice_regs: per-voice INC/CTRL register file, write decode, read by idx.
//  Top holds FSM, idx counter, phase array, accumulator, output regs. LUT instantiated outside.
// TESTING (bench models LUT with the standard 64-entry wave table: LUT[0]=0x3FFF, LUT[1]=0x3C0F,
//  LUT[32]=0x0000; NUM_VOICES=4, PHASE_W=16)
//  Reset: after reset_n release all outputs 0; sample_stb with no voices enabled -> mix_o=0x0000, valid
//   exactly 6 edges after strobe edge.
//  Voice 0 INC=0x0400, enabled: strobe 1 -> mix_o=0x3FFF>>2=0x0FFF; strobe 2 -> 0x3C0F>>2=0x0F03.
//  All 4 voices INC=0 enabled -> mix_o=0x3FFF every sample; ramp_o=0 for all RUN cycles.
//  Wrap: voice 0 INC=0x8000 -> ramp alternates 0,32 -> mix_o 0x0FFF, 0x0000, 0x0FFF.
//  Overrun: strobe, then strobe 2 cycles later -> overrun_o one pulse, single mix_valid_o.
//  Reset mid-RUN (assert at idx 2) -> no mix_valid_o, mix_o=0, next strobe mixes from phase 0.
//  VOICE_ATTEN_EN: voice 0 INC=0, atten=2 -> mix_o=(0x3FFF>>2)>>2=0x03FF; undefined -> 0x0FFF.

Source files
------------

// File: rtl/wave_voice_pkg.sv
// Shared types and constants for the wave voice scheduler.
package wave_voice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int   RAMP_W         = 6;
  localparam int   SAMPLE_W       = 16;
  localparam logic REG_INC        = 1'b0;
  localparam logic REG_CTRL       = 1'b1;
  localparam int   CTRL_EN_BIT    = 0;
  localparam int   CTRL_ATTEN_LSB = 1;
  localparam int   CTRL_ATTEN_W   = 2;

endpackage

// File: rtl/wave_voice_regs.sv
// Per-voice INC/CTRL register file with write decode and read-by-index.
// VOICE_ATTEN_EN: also stores CTRL[2:1] as a per-voice attenuation shift.
module wave_voice_regs
  import wave_voice_pkg::*;
#(
  parameter int  NUM_VOICES = 4,
  parameter int  PHASE_W    = 16,
  localparam int VW         = $clog2(NUM_VOICES),
  localparam int AW         = VW + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic [SAMPLE_W-1:0]     i_wr_data,
  input  logic [VW-1:0]           i_rd_idx,
  output logic [PHASE_W-1:0]      o_inc,
  output logic                    o_en,
  output logic [CTRL_ATTEN_W-1:0] o_atten
);

  logic [PHASE_W-1:0]    r_inc [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_en;
  logic [VW-1:0]         w_voice;
  logic                  w_sel;

  assign w_voice = i_wr_addr[AW-1:1];
  assign w_sel   = i_wr_addr[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) r_inc[v] <= '0;
      r_en <= '0;
    end else if (i_wr_en) begin
      if (w_sel == REG_INC) r_inc[w_voice] <= PHASE_W'(i_wr_data);
      else                  r_en[w_voice]  <= i_wr_data[CTRL_EN_BIT];
    end
  end

  assign o_inc = r_inc[i_rd_idx];
  assign o_en  = r_en[i_rd_idx];

`ifdef VOICE_ATTEN_EN
  logic [CTRL_ATTEN_W-1:0] r_atten [NUM_VOICES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) r_atten[v] <= '0;
    end else if (i_wr_en && w_sel == REG_CTRL) begin
      r_atten[w_voice] <= i_wr_data[CTRL_ATTEN_LSB +: CTRL_ATTEN_W];
    end
  end

  assign o_atten = r_atten[i_rd_idx];
`else
  assign o_atten = '0;
`endif

endmodule

// File: rtl/wave_voice_sched.sv
// Walks NUM_VOICES phase accumulators through one shared wave LUT and mixes them.
// VOICE_ATTEN_EN: per-voice contribution is shifted right by its CTRL attenuation.
//   state | meaning
//   IDLE  | waiting for sample_stb
//   RUN   | one voice per clock: accumulate LUT sample, advance phase
//   DONE  | publish acc/NUM_VOICES to mix_o, valid pulse follows
module wave_voice_sched
  import wave_voice_pkg::*;
#(
  parameter int  NUM_VOICES = 4,
  parameter int  PHASE_W    = 16,
  localparam int VW         = $clog2(NUM_VOICES),
  localparam int AW         = VW + 1,
  localparam int ACC_W      = SAMPLE_W + VW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_stb,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic [RAMP_W-1:0]   ramp_o,
  input  logic [SAMPLE_W-1:0] lut_i,
  output logic [SAMPLE_W-1:0] mix_o,
  output logic                mix_valid_o,
  output logic                busy_o,
  output logic                overrun_o
);

  state_t                  r_state, w_state_nxt;
  logic [VW-1:0]           r_idx;
  logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
  logic [ACC_W-1:0]        r_acc;
  logic [SAMPLE_W-1:0]     r_mix;
  logic                    r_valid_pend, r_mix_valid, r_overrun;

  logic [PHASE_W-1:0]      w_inc;
  logic                    w_en;
  logic [CTRL_ATTEN_W-1:0] w_atten;
  logic [SAMPLE_W-1:0]     w_gated, w_contrib;
  logic [RAMP_W-1:0]       w_ramp;

  wave_voice_regs #(.NUM_VOICES(NUM_VOICES), .PHASE_W(PHASE_W)) u_regs (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_idx  (r_idx),
    .o_inc     (w_inc),
    .o_en      (w_en),
    .o_atten   (w_atten)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ramp      = '0;
    case (r_state)
      IDLE: if (sample_stb) w_state_nxt = RUN;
      RUN: begin
        w_ramp = r_phase[r_idx][PHASE_W-1 -: RAMP_W];
        if (r_idx == VW'(NUM_VOICES - 1)) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A disabled voice is silent rather than reading LUT[0].
  assign w_gated   = w_en ? lut_i : '0;
  assign w_contrib = w_gated >> w_atten;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_mix        <= '0;
      r_valid_pend <= 1'b0;
      r_mix_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) r_phase[v] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_overrun    <= sample_stb && (r_state != IDLE);
      r_mix_valid  <= r_valid_pend;
      r_valid_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sample_stb) begin
            r_idx <= '0;
            r_acc <= '0;
          end
        end
        RUN: begin
          r_acc          <= r_acc + ACC_W'(w_contrib);
          r_phase[r_idx] <= w_en ? r_phase[r_idx] + w_inc : '0;
          r_idx          <= r_idx + 1'b1;
        end
        DONE: begin
          r_mix        <= SAMPLE_W'(r_acc >> VW);
          r_valid_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ramp_o      = w_ramp;
  assign mix_o       = r_mix;
  assign mix_valid_o = r_mix_valid;
  assign busy_o      = (r_state != IDLE);
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_wave_voice_sched.sv
// Self-checking bench for wave_voice_sched against a per-sample arithmetic model.
module tb_wave_voice_sched;
  localparam int NV = 4;
  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        reset_n, sample_stb, wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data, lut_i, mix_o;
  logic [5:0]  ramp_o;
  logic        mix_valid_o, busy_o, overrun_o;

  logic [15:0] lut_tab [64];
  assign lut_i = lut_tab[ramp_o];

  always #5 clk = ~clk;

  wave_voice_sched #(.NUM_VOICES(NV), .PHASE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .sample_stb(sample_stb), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ramp_o(ramp_o), .lut_i(lut_i),
    .mix_o(mix_o), .mix_valid_o(mix_valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] m_inc   [NV];
  logic [15:0] m_phase [NV];
  bit          m_en    [NV];
  int          m_att   [NV];
  logic [5:0]  seen_ramp [4];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_inc[v] = 0; m_phase[v] = 0; m_en[v] = 0; m_att[v] = 0;
    end
  endtask

  // One mixed sample: average of enabled voices' (attenuated) LUT values, then phases advance.
  task automatic model_step(output logic [15:0] exp_mix, output logic [5:0] exp_ramp0);
    int sum;
    sum = 0;
    exp_ramp0 = m_phase[0][15:10];
    for (int v = 0; v < NV; v++) begin
      int s;
      s = m_en[v] ? int'(lut_tab[m_phase[v][15:10]]) : 0;
      s = s >> m_att[v];
      sum += s;
      m_phase[v] = m_en[v] ? m_phase[v] + m_inc[v] : 16'h0000;
    end
    exp_mix = 16'(sum / NV);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; sample_stb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic write_reg(input int v, input bit sel, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = {2'(v), sel}; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (!sel) m_inc[v] = d;
    else begin
      m_en[v] = d[0];
`ifdef VOICE_ATTEN_EN
      m_att[v] = int'(d[2:1]);
`endif
    end
  endtask

  // Strobe once; lat = edges after the strobe edge to the first valid (0 = never).
  task automatic run_sample(output logic [15:0] mix, output int lat, output int nvalid);
    @(negedge clk);
    sample_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_stb = 1'b0;
    seen_ramp[0] = ramp_o;
    lat = 0; nvalid = 0; mix = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 3) seen_ramp[k] = ramp_o;
      if (mix_valid_o) begin
        nvalid++;
        if (lat == 0) begin lat = k; mix = mix_o; end
      end
    end
  endtask

  task automatic check_sample(input string name);
    logic [15:0] got, exp;
    logic [5:0]  er;
    int lat, nv;
    model_step(exp, er);
    run_sample(got, lat, nv);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s mix: got %h expected %h", name, got, exp); end
    checks++;
    if (lat !== 6 || nv !== 1) begin
      errors++; $display("FAIL %s latency: got lat=%0d pulses=%0d expected lat=6 pulses=1", name, lat, nv);
    end
    checks++;
    if (seen_ramp[0] !== er) begin
      errors++; $display("FAIL %s ramp0: got %0d expected %0d", name, seen_ramp[0], er);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mix_o, mix_valid_o, busy_o, overrun_o, ramp_o} !== 25'h0) begin
      errors++;
      $display("FAIL reset_outputs: got mix=%h v=%b b=%b o=%b r=%h expected all 0",
               mix_o, mix_valid_o, busy_o, overrun_o, ramp_o);
    end
    check_sample("reset_silent");
  endtask

  task automatic test_single_voice();
    do_reset();
    write_reg(0, 1'b0, 16'h0400);
    write_reg(0, 1'b1, 16'h0001);
    check_sample("single_s1");
    check_sample("single_s2");
    check_sample("single_s3");
  endtask

  task automatic test_all_voices();
    do_reset();
    for (int v = 0; v < NV; v++) begin
      write_reg(v, 1'b0, 16'h0000);
      write_reg(v, 1'b1, 16'h0001);
    end
    for (int s = 0; s < 3; s++) begin
      check_sample("all_max");
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seen_ramp[k] !== 6'd0) begin
          errors++; $display("FAIL all_ramp slot%0d: got %0d expected 0", k, seen_ramp[k]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    write_reg(0, 1'b0, 16'h8000);
    write_reg(0, 1'b1, 16'h0001);
    repeat (3) check_sample("wrap");
  endtask

  task automatic test_atten();
    do_reset();
    write_reg(0, 1'b0, 16'h0000);
    write_reg(0, 1'b1, 16'h0005);
    check_sample("atten");
  endtask

  task automatic test_overrun();
    logic [15:0] exp, got;
    logic [5:0] er;
    logic ov1, ov2;
    int nv;
    do_reset();
    write_reg(0, 1'b0, 16'h0400);
    write_reg(0, 1'b1, 16'h0001);
    model_step(exp, er);
    @(negedge clk); sample_stb = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_stb = 1'b0;
    @(posedge clk);
    @(negedge clk); sample_stb = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_stb = 1'b0; ov1 = overrun_o;
    @(posedge clk);
    @(negedge clk); ov2 = overrun_o;
    nv = 0; got = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (mix_valid_o) begin nv++; got = mix_o; end
    end
    checks++;
    if (ov1 !== 1'b1 || ov2 !== 1'b0) begin
      errors++; $display("FAIL overrun_pulse: got %b%b expected 10", ov1, ov2);
    end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL overrun_valids: got %0d expected 1", nv); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL overrun_mix: got %h expected %h", got, exp); end
  endtask

  task automatic test_done_edge_strobe();
    logic [15:0] exp;
    logic [5:0] er;
    logic b, ov;
    int nv;
    do_reset();
    write_reg(1, 1'b0, 16'h0C00);
    write_reg(1, 1'b1, 16'h0001);
    model_step(exp, er);
    @(negedge clk); sample_stb = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_stb = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    b = busy_o;
    sample_stb = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_stb = 1'b0; ov = overrun_o;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (mix_valid_o) nv++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (b !== 1'b1 || ov !== 1'b1) begin
      errors++; $display("FAIL done_edge_strobe: got busy=%b ovr=%b expected 1 1", b, ov);
    end
    checks++;
    if (nv !== 1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL done_edge_ignored: got pulses=%0d busy=%b expected 1 0", nv, busy_o);
    end
    check_sample("after_done_edge");
  endtask

  task automatic test_reset_mid_run();
    int nv;
    do_reset();
    write_reg(0, 1'b0, 16'h0400);
    write_reg(0, 1'b1, 16'h0001);
    check_sample("pre_reset1");
    check_sample("pre_reset2");
    @(negedge clk); sample_stb = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mix_o !== 16'h0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got mix=%h busy=%b expected 0000 0", mix_o, busy_o);
    end
    reset_n = 1'b1;
    model_reset();
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (mix_valid_o) nv++;
    end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL midrun_no_valid: got %0d expected 0", nv); end
    write_reg(0, 1'b0, 16'h0400);
    write_reg(0, 1'b1, 16'h0001);
    check_sample("post_reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 20; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        write_reg($urandom_range(0, NV - 1), 1'($urandom_range(0, 1)), 16'($urandom));
      end
      check_sample("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) lut_tab[i] = 16'((i * 16'h0913 + 16'h1234) & 16'h3FFF);
    lut_tab[0]  = 16'h3FFF;
    lut_tab[1]  = 16'h3C0F;
    lut_tab[32] = 16'h0000;
    reset_n = 1'b0; sample_stb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();

    test_reset();
    test_single_voice();
    test_all_voices();
    test_wrap();
    test_atten();
    test_overrun();
    test_done_edge_strobe();
    test_reset_mid_run();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
